// File: rtl/rv32f_fp_reg_file.sv
// RV32F floating-point register file with issue scoreboard and fcsr state.
// Serves decode operand reads/busy status and absorbs writeback data and flags.
module rv32f_fp_reg_file #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  f_rs1,
    input  logic [4:0]  f_rs2,
    output logic [31:0] f_rs1_data,
    output logic [31:0] f_rs2_data,
    input  logic        rden,
    input  logic [4:0]  rd_decode,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    input  logic [2:0]  f_frm_in,
    output logic [2:0]  f_frm,
    input  logic        f_wen,
    input  logic [4:0]  f_rd,
    input  logic [31:0] f_wdata,
    input  logic [4:0]  f_flags,
    input  logic        flush,
    input  logic        csr_wen,
    input  logic [1:0]  csr_sel,
    input  logic [7:0]  csr_wdata,
    output logic [7:0]  csr_rdata,
    output logic        clear_status
);

    localparam logic [2:0] FRM_DYN = 3'b111;

    logic [31:0]         regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [4:0]          fflags_q;
    logic [4:0]          fflags_d;
    logic [2:0]          frm_q;
    logic [2:0]          frm_d;
    logic                clear_status_q;
    logic                clear_status_d;

    // Operand reads with write-through bypass from the writeback port.
    always_comb begin
        if (f_wen && (f_rd == f_rs1)) begin
            f_rs1_data = f_wdata;
        end else begin
            f_rs1_data = regs_q[f_rs1];
        end
        if (f_wen && (f_rd == f_rs2)) begin
            f_rs2_data = f_wdata;
        end else begin
            f_rs2_data = regs_q[f_rs2];
        end
    end

    // Busy status; a same-cycle writeback already resolves the hazard.
    always_comb begin
        rs1_busy = busy_q[f_rs1]     & ~(f_wen & (f_rd == f_rs1));
        rs2_busy = busy_q[f_rs2]     & ~(f_wen & (f_rd == f_rs2));
        rd_busy  = busy_q[rd_decode] & ~(f_wen & (f_rd == rd_decode));
    end

    // Scoreboard next state: set beats clear on the same index, flush beats both.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (rden) begin
            set_mask_s[rd_decode] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (f_wen) begin
            clr_mask_s[f_rd] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
        end
        clear_status_d = (busy_q != '0) && (busy_d == '0);
    end

    // fcsr next state; writeback flags accumulate on top of any CSR write.
    always_comb begin
        if (csr_wen && csr_sel[0]) begin
            fflags_d = csr_wdata[4:0];
        end else begin
            fflags_d = fflags_q;
        end
        if (f_wen) begin
            fflags_d = fflags_d | f_flags;
        end else begin
            fflags_d = fflags_d;
        end
        if (csr_wen && csr_sel[1]) begin
            frm_d = csr_wdata[7:5];
        end else begin
            frm_d = frm_q;
        end
    end

    // Dynamic rounding-mode resolution for decode.
    always_comb begin
        if (f_frm_in == FRM_DYN) begin
            f_frm = frm_q;
        end else begin
            f_frm = f_frm_in;
        end
    end

    // CSR read view of the current (pre-update) fcsr state.
    always_comb begin
        case (csr_sel)
            2'b01:   csr_rdata = {3'b000, fflags_q};
            2'b10:   csr_rdata = {frm_q, 5'b00000};
            2'b11:   csr_rdata = {frm_q, fflags_q};
            default: csr_rdata = 8'h00;
        endcase
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (f_wen) begin
            regs_q[f_rd] <= f_wdata;
        end
    end

    // Scoreboard, fcsr and empty-pulse state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            fflags_q       <= 5'b00000;
            frm_q          <= 3'b000;
            clear_status_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            fflags_q       <= fflags_d;
            frm_q          <= frm_d;
            clear_status_q <= clear_status_d;
        end
    end

    assign clear_status = clear_status_q;

endmodule

// File: tb/tb_rv32f_fp_reg_file.sv
// Directed bench for rv32f_fp_reg_file with hand-computed expectations.
module tb_rv32f_fp_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [31:0] f_rs1_data;
    logic [31:0] f_rs2_data;
    logic        rden;
    logic [4:0]  rd_decode;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic [2:0]  f_frm_in;
    logic [2:0]  f_frm;
    logic        f_wen;
    logic [4:0]  f_rd;
    logic [31:0] f_wdata;
    logic [4:0]  f_flags;
    logic        flush;
    logic        csr_wen;
    logic [1:0]  csr_sel;
    logic [7:0]  csr_wdata;
    logic [7:0]  csr_rdata;
    logic        clear_status;

    int checks_cnt;
    int fail_cnt;

    rv32f_fp_reg_file dut (
        .clk          (clk),
        .rst          (rst),
        .f_rs1        (f_rs1),
        .f_rs2        (f_rs2),
        .f_rs1_data   (f_rs1_data),
        .f_rs2_data   (f_rs2_data),
        .rden         (rden),
        .rd_decode    (rd_decode),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_busy      (rd_busy),
        .f_frm_in     (f_frm_in),
        .f_frm        (f_frm),
        .f_wen        (f_wen),
        .f_rd         (f_rd),
        .f_wdata      (f_wdata),
        .f_flags      (f_flags),
        .flush        (flush),
        .csr_wen      (csr_wen),
        .csr_sel      (csr_sel),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .clear_status (clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs settle 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rden = 1'b0; f_wen = 1'b0; flush = 1'b0; csr_wen = 1'b0;
        f_flags = 5'b00000; f_wdata = 32'h0000_0000;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b1;
        f_rs1 = 5'd0; f_rs2 = 5'd0; rd_decode = 5'd0; f_rd = 5'd0;
        f_frm_in = 3'b111; csr_sel = 2'b11; csr_wdata = 8'h00;
        idle_inputs();
        step();
        step();

        // Reset state, read while reset is still asserted
        for (int i = 0; i < 32; i++) begin
            f_rs1 = 5'(i); f_rs2 = 5'(31 - i); rd_decode = 5'(i);
            #1;
            check_eq("rst_rs1_data", f_rs1_data, 32'h0000_0000);
            check_eq("rst_rs2_data", f_rs2_data, 32'h0000_0000);
            check_eq("rst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        end
        check_eq("rst_fcsr", {24'd0, csr_rdata}, 32'h0000_0000);
        check_eq("rst_clear_status", {31'd0, clear_status}, 32'd0);
        check_eq("rst_frm_dyn", {29'd0, f_frm}, 32'd0);
        f_frm_in = 3'b011;
        #1;
        check_eq("rst_frm_pass", {29'd0, f_frm}, 32'd3);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Write-through bypass, then array readback
        f_wen = 1'b1; f_rd = 5'd5; f_wdata = 32'h3F80_0000; f_rs1 = 5'd5; f_rs2 = 5'd6;
        #1;
        check_eq("bypass_rs1", f_rs1_data, 32'h3F80_0000);
        check_eq("nobypass_rs2", f_rs2_data, 32'h0000_0000);
        step();
        idle_inputs();
        f_rs2 = 5'd5;
        #1;
        check_eq("array_rs1", f_rs1_data, 32'h3F80_0000);
        check_eq("array_rs2", f_rs2_data, 32'h3F80_0000);

        // Issue f7, then retire it
        rden = 1'b1; rd_decode = 5'd7; f_rs1 = 5'd7;
        #1;
        check_eq("issue_rd_busy_pre", {31'd0, rd_busy}, 32'd0);
        step();
        idle_inputs();
        #1;
        check_eq("busy7_set", {31'd0, rs1_busy}, 32'd1);
        check_eq("rd_busy7", {31'd0, rd_busy}, 32'd1);
        check_eq("no_pulse_on_issue", {31'd0, clear_status}, 32'd0);
        f_wen = 1'b1; f_rd = 5'd7; f_wdata = 32'h4000_0000;
        #1;
        check_eq("busy7_masked", {31'd0, rs1_busy}, 32'd0);
        check_eq("rd_busy7_masked", {31'd0, rd_busy}, 32'd0);
        check_eq("cs_before_edge", {31'd0, clear_status}, 32'd0);
        step();
        idle_inputs();
        #1;
        check_eq("busy7_cleared", {31'd0, rs1_busy}, 32'd0);
        check_eq("cs_pulse_wb", {31'd0, clear_status}, 32'd1);
        step();
        check_eq("cs_pulse_end", {31'd0, clear_status}, 32'd0);

        // Same-index set and clear: set wins, data still written
        rden = 1'b1; rd_decode = 5'd9; f_wen = 1'b1; f_rd = 5'd9; f_wdata = 32'h4040_0000;
        step();
        idle_inputs();
        f_rs1 = 5'd9;
        #1;
        check_eq("busy9_set_wins", {31'd0, rs1_busy}, 32'd1);
        check_eq("data9", f_rs1_data, 32'h4040_0000);
        check_eq("cs_none_9", {31'd0, clear_status}, 32'd0);
        f_wen = 1'b1; f_rd = 5'd9; f_wdata = 32'h4080_0000; f_flags = 5'b00001;
        step();
        idle_inputs();
        csr_sel = 2'b01;
        #1;
        check_eq("cs_pulse_9", {31'd0, clear_status}, 32'd1);
        check_eq("fflags_acc", {24'd0, csr_rdata}, 32'h01);

        // CSR write of fflags with concurrent writeback flags
        csr_wen = 1'b1; csr_sel = 2'b01; csr_wdata = 8'h00;
        f_wen = 1'b1; f_rd = 5'd10; f_wdata = 32'h1111_2222; f_flags = 5'b10000;
        #1;
        check_eq("csr_read_pre_update", {24'd0, csr_rdata}, 32'h01);
        step();
        idle_inputs();
        #1;
        check_eq("fflags_sticky_merge", {24'd0, csr_rdata}, 32'h10);
        check_eq("cs_empty_to_empty", {31'd0, clear_status}, 32'd0);

        // frm write and dynamic resolution
        csr_wen = 1'b1; csr_sel = 2'b10; csr_wdata = 8'b010_11111;
        step();
        idle_inputs();
        f_frm_in = 3'b111;
        #1;
        check_eq("frm_dyn", {29'd0, f_frm}, 32'd2);
        check_eq("csr_frm_only", {24'd0, csr_rdata}, 32'h40);
        f_frm_in = 3'b001;
        #1;
        check_eq("frm_static", {29'd0, f_frm}, 32'd1);
        f_frm_in = 3'b110;
        #1;
        check_eq("frm_invalid_pass", {29'd0, f_frm}, 32'd6);
        csr_sel = 2'b11;
        #1;
        check_eq("csr_fcsr", {24'd0, csr_rdata}, 32'h50);
        csr_sel = 2'b00;
        #1;
        check_eq("csr_none", {24'd0, csr_rdata}, 32'h00);

        // Issue f3 and f4, then flush with competing issue and a writeback
        rden = 1'b1; rd_decode = 5'd3;
        step();
        rd_decode = 5'd4;
        step();
        idle_inputs();
        f_rs1 = 5'd3; f_rs2 = 5'd4;
        #1;
        check_eq("busy3_4", {30'd0, rs1_busy, rs2_busy}, 32'd3);
        flush = 1'b1; rden = 1'b1; rd_decode = 5'd12;
        f_wen = 1'b1; f_rd = 5'd20; f_wdata = 32'h1234_5678;
        step();
        idle_inputs();
        rd_decode = 5'd12;
        #1;
        check_eq("flush_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        check_eq("cs_pulse_flush", {31'd0, clear_status}, 32'd1);
        f_rs1 = 5'd20;
        #1;
        check_eq("flush_data_written", f_rs1_data, 32'h1234_5678);
        step();
        check_eq("cs_flush_single", {31'd0, clear_status}, 32'd0);

        // Asynchronous reset mid-operation
        rden = 1'b1; rd_decode = 5'd15; f_wen = 1'b1; f_rd = 5'd1; f_wdata = 32'h0000_0001;
        f_flags = 5'b00100;
        step();
        idle_inputs();
        f_rs1 = 5'd15; f_rs2 = 5'd5; csr_sel = 2'b11;
        #1;
        check_eq("pre_rst_busy15", {31'd0, rs1_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {31'd0, rs1_busy}, 32'd0);
        check_eq("mid_rst_data", f_rs2_data, 32'h0000_0000);
        check_eq("mid_rst_fcsr", {24'd0, csr_rdata}, 32'h00);
        step();
        rst = 1'b0;
        step();
        check_eq("post_rst_cs", {31'd0, clear_status}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rv32f_fp_reg_file.md
# rv32f_fp_reg_file

Floating-point register file and scoreboard for the RV32F extension. It is the responder behind the FP register-file interface: it serves decode-stage operand reads, tracks in-flight destinations, and absorbs writeback-stage writes and exception flags. It also owns the fcsr state (fflags, frm) and resolves dynamic rounding mode for decode. It sits between the decode stage and the FP writeback stage, alongside the integer register file.

## Interface
- NUM_REGS, 32, number of FP registers; index width 5
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- f_rs1, f_rs2  in  5 each  decode source selects
- f_rs1_data, f_rs2_data  out  32 each  source operands
- rden  in  1  decode issues an FP-writing instruction this cycle
- rd_decode  in  5  destination of the issuing instruction
- rs1_busy, rs2_busy, rd_busy  out  1 each  scoreboard status of f_rs1, f_rs2, rd_decode
- f_frm_in  in  3  instruction rm field
- f_frm  out  3  resolved rounding mode
- f_wen  in  1  writeback write strobe
- f_rd  in  5  writeback destination
- f_wdata  in  32  writeback data
- f_flags  in  5  exception flags of the retiring instruction (NV,DZ,OF,UF,NX)
- flush  in  1  pipeline flush; clears the scoreboard
- csr_wen  in  1  fcsr write strobe
- csr_sel  in  2  01 fflags, 10 frm, 11 fcsr; 00 means no access
- csr_wdata  in  8  write data, fcsr layout {frm[2:0], fflags[4:0]}
- csr_rdata  out  8  read data, same layout, zero-filled for the unselected field
- clear_status  out  1  one-cycle pulse: scoreboard became empty

## Operation
- Register array: 32x32 bits. f0 is an ordinary register and is not hardwired to zero.
- Reads are combinational. If f_wen is high and f_rd equals the read select, the read returns f_wdata (write-through bypass). Otherwise it returns the array value.
- Write: when f_wen is high, regs[f_rd] is loaded with f_wdata at the clock edge.
- Scoreboard: 32 busy bits.
  - Set: rden sets busy[rd_decode].
  - Clear: f_wen clears busy[f_rd].
  - Same index set and cleared in the same cycle: set wins, because the new producer is issuing.
  - Different indices: both take effect.
  - flush clears all bits and takes priority over rden and f_wen set/clear; the data write itself still occurs.
- Busy outputs:
  - rs1_busy = busy[f_rs1] & ~(f_wen & f_rd==f_rs1). rs2_busy follows the same rule with f_rs2.
  - rd_busy = busy[rd_decode], with the same writeback masking.
  - Decode stalls on any of these; this block does not stall anything itself.
- clear_status: registered. It is high for exactly one cycle after any edge where the scoreboard goes from non-empty to all-zero, whether by writeback or by flush. An empty-to-empty transition does not pulse.
- fflags are sticky. Next value = (csr_wen & csr_sel[0] ? csr_wdata[4:0] : fflags) | (f_wen ? f_flags : 0). Writeback flags in the same cycle as a CSR write are never lost.
- frm: loaded from csr_wdata[7:5] when csr_wen & csr_sel[1].
- f_frm is combinational:
  - f_frm_in == 3'b111 (DYN): output frm.
  - Any other value: output f_frm_in.
  - Invalid encodings 101/110 pass through unchanged; decode raises the illegal-instruction exception.
- csr_rdata is combinational from current registers, before any same-cycle update:
  - sel 01: {3'b0, fflags}
  - sel 10: {frm, 5'b0}
  - sel 11: {frm, fflags}
  - sel 00: 0

## Timing
- Reset (async assert, synchronous release on the next clk edge) sets: all registers to 0, busy to 0, fflags to 0, frm to 0 (RNE), clear_status to 0.
- Output values during and immediately after reset:
  - Data outputs read 0.
  - All busy outputs read 0.
  - f_frm equals f_frm_in, or 0 if f_frm_in is DYN.
- Read latency is 0 cycles. A write becomes visible in the same cycle via bypass and in the array from the next cycle.
- A busy bit set by rden is visible the cycle after issue. A clear via f_wen is visible in the same cycle through masking.
- clear_status appears one cycle after the emptying edge.
- rst asserted mid-operation discards in-flight scoreboard state and pending flag accumulation with no partial update.

## Test plan
- Reset, then read f0..f31 → all data 0, all busy 0, csr_rdata (sel 11) = 0, clear_status 0.
- Write f5 = 0x3F800000 with f_rs1=5 in the same cycle → f_rs1_data = 0x3F800000 that cycle and again the next cycle with f_wen low.
- Issue rden rd_decode=7 → rs1_busy=1 for f_rs1=7 next cycle. Then writeback f_rd=7 → rs1_busy=0 in that cycle, and clear_status=1 exactly one cycle later.
- Same cycle rden rd_decode=9 and f_wen f_rd=9 → busy[9]=1 afterwards, with the data written.
- fflags=5'b00001, then csr write fflags=5'b00000 with f_wen f_flags=5'b10000 in the same cycle → fflags=5'b10000.
- CSR write frm=3'b010, then f_frm_in=3'b111 → f_frm=3'b010. f_frm_in=3'b001 → f_frm=3'b001. Issue to f3 and f4, then flush → all busy 0 and a single clear_status pulse.
